// File: rtl/nasti_stream_writer.sv
// Stream-to-memory mover: writes a (dst, len) request as INCR bursts of at most MAX_BURST_LENGTH beats.
// W is a zero-latency pass-through of the stream; one burst is outstanding, and the next AW waits for B.
module nasti_stream_writer #(
    parameter int ADDR_WIDTH       = 64,
    parameter int DATA_WIDTH       = 64,
    parameter int MAX_BURST_LENGTH = 8,
    parameter int ID_WIDTH         = 1,
    parameter int USER_WIDTH       = 1
) (
    input  logic                      aclk_i,
    input  logic                      aresetn_i,
    // stream source
    input  logic [DATA_WIDTH-1:0]     src_t_data_i,
    input  logic                      src_t_valid_i,
    input  logic                      src_t_last_i,
    output logic                      src_t_ready_o,
    // memory write address
    output logic [ID_WIDTH-1:0]       dest_aw_id_o,
    output logic [ADDR_WIDTH-1:0]     dest_aw_addr_o,
    output logic [7:0]                dest_aw_len_o,
    output logic [2:0]                dest_aw_size_o,
    output logic [1:0]                dest_aw_burst_o,
    output logic                      dest_aw_lock_o,
    output logic [3:0]                dest_aw_cache_o,
    output logic [2:0]                dest_aw_prot_o,
    output logic [3:0]                dest_aw_qos_o,
    output logic [3:0]                dest_aw_region_o,
    output logic [USER_WIDTH-1:0]     dest_aw_user_o,
    output logic                      dest_aw_valid_o,
    input  logic                      dest_aw_ready_i,
    // memory write data
    output logic [DATA_WIDTH-1:0]     dest_w_data_o,
    output logic [DATA_WIDTH/8-1:0]   dest_w_strb_o,
    output logic                      dest_w_last_o,
    output logic [USER_WIDTH-1:0]     dest_w_user_o,
    output logic                      dest_w_valid_o,
    input  logic                      dest_w_ready_i,
    // memory write response
    input  logic [1:0]                dest_b_resp_i,
    input  logic                      dest_b_valid_i,
    output logic                      dest_b_ready_o,
    // unused read half
    output logic                      dest_ar_valid_o,
    output logic                      dest_r_ready_o,
    // request / status
    input  logic [ADDR_WIDTH-1:0]     w_dst_i,
    input  logic [ADDR_WIDTH-1:0]     w_len_i,
    input  logic                      w_valid_i,
    output logic                      w_ready_o,
    output logic [1:0]                err_o
);

    localparam int DATA_BYTE_CNT = DATA_WIDTH / 8;
    localparam int ADDR_SHIFT    = $clog2(DATA_BYTE_CNT);
    localparam int BEAT_W        = ADDR_WIDTH - ADDR_SHIFT;
    localparam logic [BEAT_W-1:0] MAX_BEATS = BEAT_W'(MAX_BURST_LENGTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BEAT_W-1:0]       remain_q, remain_d;
    logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
    logic [7:0]              aw_len_q, aw_len_d;
    logic [7:0]              beat_cnt_q, beat_cnt_d;
    logic [1:0]              err_q, err_d;

    logic [BEAT_W-1:0]       burst_beats;
    logic [8:0]              burst_beats9;
    logic                    req_hs;
    logic                    w_hs;
    logic                    beat_last;
    logic                    final_beat;
    logic                    unused_ok;

    assign req_hs       = w_valid_i && (state_q == S_IDLE);
    assign burst_beats  = (remain_q > MAX_BEATS) ? MAX_BEATS : remain_q;
    assign burst_beats9 = burst_beats[8:0];
    assign w_hs         = dest_w_valid_o && dest_w_ready_i;
    assign beat_last    = (beat_cnt_q == aw_len_q);
    // remain_q already excludes the burst in flight, so zero means this is the last burst
    assign final_beat   = beat_last && (remain_q == '0);
    assign unused_ok    = ^{dest_b_resp_i[0], w_dst_i[ADDR_SHIFT-1:0], w_len_i[ADDR_SHIFT-1:0]};

    // state register
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_valid_i) state_d = S_ISSUE;
            S_ISSUE: state_d = (remain_q == '0) ? S_IDLE : S_ADDR;
            S_ADDR:  if (dest_aw_ready_i) state_d = S_DATA;
            S_DATA:  if (w_hs && beat_last) state_d = S_RESP;
            S_RESP:  if (dest_b_valid_i) state_d = S_ISSUE;
            default: state_d = S_IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        w_ready_o       = (state_q == S_IDLE);
        dest_aw_valid_o = (state_q == S_ADDR);
        dest_b_ready_o  = (state_q == S_RESP);
        dest_w_valid_o  = (state_q == S_DATA) && src_t_valid_i;
        src_t_ready_o   = (state_q == S_DATA) && dest_w_ready_i;
        dest_w_last_o   = (state_q == S_DATA) && beat_last;
    end

    // burst bookkeeping
    always_comb begin
        addr_d     = addr_q;
        remain_d   = remain_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        if (req_hs) begin
            addr_d   = {w_dst_i[ADDR_WIDTH-1:ADDR_SHIFT], {ADDR_SHIFT{1'b0}}};
            remain_d = w_len_i[ADDR_WIDTH-1:ADDR_SHIFT];
            err_d    = 2'b00;
        end
        if ((state_q == S_ISSUE) && (remain_q != '0)) begin
            aw_addr_d  = addr_q;
            aw_len_d   = 8'(burst_beats9 - 9'd1);
            addr_d     = addr_q + {burst_beats, {ADDR_SHIFT{1'b0}}};
            remain_d   = remain_q - burst_beats;
            beat_cnt_d = 8'd0;
        end
        if ((state_q == S_DATA) && w_hs) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            if (src_t_last_i != final_beat) err_d[1] = 1'b1;
        end
        if ((state_q == S_RESP) && dest_b_valid_i && dest_b_resp_i[1]) begin
            err_d[0] = 1'b1;
        end
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            addr_q     <= '0;
            remain_q   <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            beat_cnt_q <= '0;
            err_q      <= '0;
        end else begin
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    assign dest_aw_id_o     = '0;
    assign dest_aw_addr_o   = aw_addr_q;
    assign dest_aw_len_o    = aw_len_q;
    assign dest_aw_size_o   = 3'(ADDR_SHIFT);
    assign dest_aw_burst_o  = 2'b01;
    assign dest_aw_lock_o   = 1'b0;
    assign dest_aw_cache_o  = '0;
    assign dest_aw_prot_o   = '0;
    assign dest_aw_qos_o    = '0;
    assign dest_aw_region_o = '0;
    assign dest_aw_user_o   = '0;
    assign dest_w_data_o    = src_t_data_i;
    assign dest_w_strb_o    = '1;
    assign dest_w_user_o    = '0;
    assign dest_ar_valid_o  = 1'b0;
    assign dest_r_ready_o   = 1'b0;
    assign err_o            = err_q;

    // requests must be beat aligned in both address and length
    assert property (@(posedge aclk_i) disable iff (!aresetn_i)
        req_hs |-> ((w_dst_i[ADDR_SHIFT-1:0] == '0) && (w_len_i[ADDR_SHIFT-1:0] == '0)));

endmodule

// File: tb/tb_nasti_stream_writer.sv
// Randomized bench for nasti_stream_writer: request-level reference model plus per-cycle protocol checks.
module tb_nasti_stream_writer;
    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int MAXB = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0]   src_t_data = '0;
    logic            src_t_valid = 1'b0, src_t_last = 1'b0, src_t_ready;
    logic [0:0]      aw_id, aw_user, w_user;
    logic [AW-1:0]   aw_addr;
    logic [7:0]      aw_len;
    logic [2:0]      aw_size, aw_prot;
    logic [1:0]      aw_burst;
    logic            aw_lock, aw_valid;
    logic [3:0]      aw_cache, aw_qos, aw_region;
    logic            aw_ready = 1'b0;
    logic [DW-1:0]   w_data;
    logic [DW/8-1:0] w_strb;
    logic            w_last, w_valid;
    logic            w_ready = 1'b0;
    logic [1:0]      b_resp = 2'b00;
    logic            b_valid = 1'b0, b_ready;
    logic            ar_valid, r_ready;
    logic [AW-1:0]   req_dst = '0, req_len = '0;
    logic            req_valid = 1'b0, req_ready;
    logic [1:0]      err;

    nasti_stream_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST_LENGTH(MAXB)) dut (
        .aclk_i(clk), .aresetn_i(rst_n),
        .src_t_data_i(src_t_data), .src_t_valid_i(src_t_valid), .src_t_last_i(src_t_last),
        .src_t_ready_o(src_t_ready),
        .dest_aw_id_o(aw_id), .dest_aw_addr_o(aw_addr), .dest_aw_len_o(aw_len),
        .dest_aw_size_o(aw_size), .dest_aw_burst_o(aw_burst), .dest_aw_lock_o(aw_lock),
        .dest_aw_cache_o(aw_cache), .dest_aw_prot_o(aw_prot), .dest_aw_qos_o(aw_qos),
        .dest_aw_region_o(aw_region), .dest_aw_user_o(aw_user), .dest_aw_valid_o(aw_valid),
        .dest_aw_ready_i(aw_ready),
        .dest_w_data_o(w_data), .dest_w_strb_o(w_strb), .dest_w_last_o(w_last),
        .dest_w_user_o(w_user), .dest_w_valid_o(w_valid), .dest_w_ready_i(w_ready),
        .dest_b_resp_i(b_resp), .dest_b_valid_i(b_valid), .dest_b_ready_o(b_ready),
        .dest_ar_valid_o(ar_valid), .dest_r_ready_o(r_ready),
        .w_dst_i(req_dst), .w_len_i(req_len), .w_valid_i(req_valid), .w_ready_o(req_ready),
        .err_o(err)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } beat_t;

    // reference model state for the request in progress
    bit            model_en = 1'b0;
    int            total = 0;
    logic [63:0]   m_dst = '0;
    logic [63:0]   exp_data[$];
    beat_t         stream_q[$];
    int            aw_idx = 0, w_idx = 0, b_idx = 0, outstanding = 0;
    int            err_burst = -1;
    int            t_pct = 100, rdy_pct = 100;
    bit            t_taken = 1'b0, b_taken = 1'b0, b_pending = 1'b0;
    int            cyc = 0, last_b_cyc = 0;
    logic [63:0]   aw_addr_log[$];
    int            aw_len_log[$];
    int            wlast_log[$];
    logic [63:0]   wdata_log[$];
    bit            prev_awv = 1'b0;
    logic [63:0]   prev_awaddr = '0;
    logic [7:0]    prev_awlen = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // compare process
    always @(negedge clk) begin
        if (rst_n && model_en) begin
            if (prev_awv) begin
                chk("aw_valid_held", aw_valid, 1'b1);
                chk("aw_addr_stable", aw_addr, prev_awaddr);
                chk("aw_len_stable", aw_len, prev_awlen);
            end
            chk("w_valid_without_t_valid", w_valid && !src_t_valid, 1'b0);
            chk("t_ready_without_w_ready", src_t_ready && !w_ready, 1'b0);
            chk("t_hs_matches_w_hs", src_t_valid && src_t_ready, w_valid && w_ready);
            if (w_valid) chk("w_data_passthru", w_data, src_t_data);
            chk("read_half_idle", {ar_valid, r_ready}, 2'b00);
            if (aw_valid && aw_ready) begin
                logic [63:0] left;
                left = 64'(total) - 64'(aw_idx) * MAXB;
                chk("aw_after_prior_b", outstanding, 0);
                chk("aw_not_extra", (aw_idx * MAXB) < total, 1'b1);
                chk("aw_addr", aw_addr, m_dst + 64'(aw_idx) * 64'(MAXB * 8));
                chk("aw_len", aw_len, ((left > MAXB) ? 64'(MAXB) : left) - 64'd1);
                chk("aw_size_burst", {aw_size, aw_burst, aw_lock}, {3'd3, 2'b01, 1'b0});
                aw_addr_log.push_back(aw_addr);
                aw_len_log.push_back(int'(aw_len));
                aw_idx++;
                outstanding++;
            end
            if (w_valid && w_ready) begin
                chk("w_inside_burst", outstanding, 1);
                chk("w_not_extra", w_idx < total, 1'b1);
                if (w_idx < total) begin
                    chk("w_data", w_data, exp_data[w_idx]);
                    chk("w_last", w_last, ((w_idx + 1) % MAXB == 0) || (w_idx == total - 1));
                end
                chk("w_strb", w_strb, {(DW/8){1'b1}});
                wdata_log.push_back(w_data);
                if (w_last) begin
                    wlast_log.push_back(w_idx + 1);
                    b_pending = 1'b1;
                end
                w_idx++;
            end
            if (src_t_valid && src_t_ready) begin
                void'(stream_q.pop_front());
                t_taken = 1'b1;
            end
            if (b_valid && b_ready) begin
                b_taken = 1'b1;
                b_idx++;
                outstanding--;
                last_b_cyc = cyc;
            end
            prev_awv    = aw_valid && !aw_ready;
            prev_awaddr = aw_addr;
            prev_awlen  = aw_len;
        end else begin
            prev_awv = 1'b0;
        end
    end

    // stream producer: holds a beat until accepted, random gaps between beats
    initial forever begin
        @(posedge clk);
        #1;
        if (t_taken) begin
            t_taken = 1'b0;
            src_t_valid = 1'b0;
        end
        if (!src_t_valid && stream_q.size() > 0 && $urandom_range(1, 100) <= t_pct) begin
            src_t_valid = 1'b1;
            src_t_data  = stream_q[0].d;
            src_t_last  = stream_q[0].l;
        end
    end

    // memory slave: random readiness, one B per completed burst
    initial forever begin
        @(posedge clk);
        #1;
        aw_ready = ($urandom_range(1, 100) <= rdy_pct);
        w_ready  = ($urandom_range(1, 100) <= rdy_pct);
        if (b_taken) begin
            b_taken = 1'b0;
            b_valid = 1'b0;
        end
        if (b_pending && !b_valid && $urandom_range(1, 100) <= rdy_pct) begin
            b_valid   = 1'b1;
            b_pending = 1'b0;
            b_resp    = (b_idx == err_burst) ? 2'b10 : ($urandom_range(0, 1) ? 2'b01 : 2'b00);
        end
    end

    // mode: 0 correct t_last, 1 last on beat 3 only, 2 data=index, 3 random t_last, 4 extra last on beat 0
    task automatic run_req(input logic [63:0] dst, input logic [63:0] len, input int mode,
                           input int eburst, input int tp, input int rp, input bit to_end);
        int    beats;
        int    nbursts;
        int    cnt;
        bit    fe;
        beat_t b;
        beats   = int'(len >> 3);
        nbursts = (beats + MAXB - 1) / MAXB;
        fe      = 1'b0;
        cnt     = 0;
        while (req_ready !== 1'b1 && cnt < 5000) begin
            @(negedge clk);
            cnt++;
        end
        chk("idle_before_req", req_ready, 1'b1);
        exp_data.delete();
        stream_q.delete();
        aw_addr_log.delete();
        aw_len_log.delete();
        wlast_log.delete();
        wdata_log.delete();
        for (int i = 0; i < beats; i++) begin
            b.d = (mode == 2) ? 64'(i) : {$urandom, $urandom};
            case (mode)
                1:       b.l = (i == 3);
                3:       b.l = ($urandom_range(0, 9) == 0) || ((i == beats - 1) && $urandom_range(0, 3) != 0);
                4:       b.l = (i == 0) || (i == beats - 1);
                default: b.l = (i == beats - 1);
            endcase
            if (b.l != (i == beats - 1)) fe = 1'b1;
            exp_data.push_back(b.d);
            stream_q.push_back(b);
        end
        total = beats;
        m_dst = dst;
        aw_idx = 0;
        w_idx = 0;
        b_idx = 0;
        err_burst = eburst;
        t_pct = tp;
        rdy_pct = rp;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_dst = dst;
        req_len = len;
        @(negedge clk);
        chk("accept_w_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("w_ready_low_n1", req_ready, 1'b0);
        chk("err_cleared_on_accept", err, 2'b00);
        @(negedge clk);
        if (beats == 0) begin
            chk("zero_len_idle_n2", req_ready, 1'b1);
            chk("zero_len_no_aw", aw_valid, 1'b0);
        end else begin
            chk("aw_valid_n2", aw_valid, 1'b1);
        end
        if (to_end) begin
            cnt = 0;
            while (req_ready !== 1'b1 && cnt < 5000) begin
                @(negedge clk);
                cnt++;
            end
            chk("req_done_in_budget", cnt < 5000, 1'b1);
            if (beats != 0) chk("w_ready_two_after_b", cyc - last_b_cyc, 2);
            chk("aw_count", aw_idx, nbursts);
            chk("w_count", w_idx, beats);
            chk("b_count", b_idx, nbursts);
            chk("stream_drained", stream_q.size(), 0);
            chk("err_final", err, {fe, (eburst >= 0) && (eburst < nbursts)});
        end
    endtask

    initial begin
        #900000;
        n_fail++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        int cnt;
        #2;
        chk("rst_w_ready", req_ready, 1'b1);
        chk("rst_err", err, 2'b00);
        chk("rst_aw_valid", aw_valid, 1'b0);
        chk("rst_b_ready", b_ready, 1'b0);
        chk("rst_w_valid_t_ready", {w_valid, src_t_ready}, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_en = 1'b1;

        run_req(64'h1000, 64'h40, 2, -1, 100, 100, 1'b1);
        chk("t1_aw_num", aw_addr_log.size(), 1);
        if (aw_addr_log.size() == 1) begin
            chk("t1_aw_addr_lit", aw_addr_log[0], 64'h1000);
            chk("t1_aw_len_lit", aw_len_log[0], 7);
        end
        chk("t1_w_num", wdata_log.size(), 8);
        for (int i = 0; i < wdata_log.size() && i < 8; i++) chk("t1_w_data_lit", wdata_log[i], 64'(i));
        chk("t1_err_lit", err, 2'b00);

        run_req(64'h2000, 64'h88, 2, -1, 100, 100, 1'b1);
        chk("t2_aw_num", aw_addr_log.size(), 3);
        chk("t2_wlast_num", wlast_log.size(), 3);
        if (aw_addr_log.size() == 3 && wlast_log.size() == 3) begin
            chk("t2_aw0_lit", {aw_addr_log[0], 8'(aw_len_log[0])}, {64'h2000, 8'd7});
            chk("t2_aw1_lit", {aw_addr_log[1], 8'(aw_len_log[1])}, {64'h2040, 8'd7});
            chk("t2_aw2_lit", {aw_addr_log[2], 8'(aw_len_log[2])}, {64'h2080, 8'd0});
            chk("t2_wlast_lit", {8'(wlast_log[0]), 8'(wlast_log[1]), 8'(wlast_log[2])}, {8'd8, 8'd16, 8'd17});
        end

        run_req(64'h3000, 64'h200, 0, -1, 60, 50, 1'b1);

        run_req(64'h4000, 64'hC0, 0, 1, 80, 70, 1'b1);
        chk("t4_err_lit", err, 2'b01);

        run_req(64'h5000, 64'h40, 1, -1, 90, 80, 1'b1);
        chk("t5_err_lit", err, 2'b10);
        chk("t5_w_lit", w_idx, 8);

        run_req(64'h6000, 64'h0, 0, -1, 100, 100, 1'b1);

        run_req(64'hFFFF_FFFF_FFFF_FFC0, 64'h80, 0, -1, 70, 70, 1'b1);
        if (aw_addr_log.size() == 2) chk("wrap_aw1_lit", aw_addr_log[1], 64'h0);

        for (int k = 0; k < 8; k++) begin
            logic [63:0] dst;
            int          nb;
            dst = {32'h0, $urandom} & ~64'h7;
            nb  = $urandom_range(0, 40);
            run_req(dst, 64'(nb) * 8, ($urandom_range(0, 2) == 0) ? 3 : 0,
                    $urandom_range(0, 3) == 0 ? $urandom_range(0, 4) : -1,
                    $urandom_range(30, 100), $urandom_range(30, 100), 1'b1);
        end

        run_req(64'h7000, 64'h200, 4, -1, 50, 50, 1'b0);
        cnt = 0;
        while (!(w_valid === 1'b1 && err[1] === 1'b1) && cnt < 5000) begin
            @(negedge clk);
            cnt++;
        end
        chk("reached_data_with_err", cnt < 5000, 1'b1);
        #2;
        model_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_aw_valid", aw_valid, 1'b0);
        chk("midrst_w_valid", w_valid, 1'b0);
        chk("midrst_w_ready", req_ready, 1'b1);
        chk("midrst_err", err, 2'b00);
        stream_q.delete();
        src_t_valid = 1'b0;
        b_valid = 1'b0;
        b_pending = 1'b0;
        t_taken = 1'b0;
        b_taken = 1'b0;
        outstanding = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_en = 1'b1;
        run_req(64'h8000, 64'h50, 0, -1, 80, 80, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
